// File: rtl/opensync_sync_info_extract.sv
// OpenSync sync-info extractor: passes the receive byte stream through with one cycle of
// latency and reports dispatch pit / compensated local time from m/s-to-m/s sync frames.
module opensync_sync_info_extract #(
    parameter int unsigned DISPATCH_PIT_OFFSET = 16,
    parameter int unsigned CORRECT_TIME_OFFSET = 24,
    parameter logic [15:0] ETHERTYPE           = 16'hFF01,
    parameter logic [7:0]  MSG_TYPE            = 8'h06,
    parameter logic [7:0]  MSG_SUBTYPE         = 8'h03
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  iv_data,
    input  logic        i_data_wr,
    output logic [7:0]  ov_data,
    output logic        o_data_wr,
    output logic [63:0] ov_dispatch_pit,
    output logic [63:0] ov_correct_time,
    output logic [63:0] ov_time_offset,
    output logic        o_sync_info_valid,
    output logic        o_sync_short_err,
    output logic [15:0] ov_sync_pkt_cnt,
    output logic [15:0] ov_sync_err_cnt
);

    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_HEADER,
        ST_CAPTURE,
        ST_WAIT_END,
        ST_DISCARD
    } state_e;

    localparam logic [10:0] PIT_FIRST    = 11'(DISPATCH_PIT_OFFSET);
    localparam logic [10:0] PIT_LAST     = 11'(DISPATCH_PIT_OFFSET + 7);
    localparam logic [10:0] TIME_FIRST   = 11'(CORRECT_TIME_OFFSET);
    localparam logic [10:0] TIME_LAST    = 11'(CORRECT_TIME_OFFSET + 7);
    localparam logic [10:0] CAP_LAST     = (PIT_LAST > TIME_LAST) ? PIT_LAST : TIME_LAST;
    localparam logic [10:0] HDR_LAST     = 11'd15;
    localparam logic [10:0] BYTE_CNT_MAX = 11'h7FF;

    state_e      state_q;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  data_q;
    logic        data_wr_q;
    logic [63:0] pit_sh_q, time_sh_q;
    logic [63:0] pit_q, time_q, offset_q;
    logic        sync_info_valid_q, short_err_q;
    logic [15:0] pkt_cnt_q, err_cnt_q;

    logic        hdr_byte_ok;
    logic        in_pit, in_time;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (!i_data_wr) begin
            byte_cnt_d = '0;
        end else if (byte_cnt_q != BYTE_CNT_MAX) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
        end
    end

    always_comb begin
        hdr_byte_ok = 1'b1;
        case (byte_cnt_q)
            11'd12:  hdr_byte_ok = (iv_data == ETHERTYPE[15:8]);
            11'd13:  hdr_byte_ok = (iv_data == ETHERTYPE[7:0]);
            11'd14:  hdr_byte_ok = (iv_data == MSG_TYPE);
            11'd15:  hdr_byte_ok = (iv_data == MSG_SUBTYPE);
            default: hdr_byte_ok = 1'b1;
        endcase
    end

    assign in_pit  = (byte_cnt_q >= PIT_FIRST)  && (byte_cnt_q <= PIT_LAST);
    assign in_time = (byte_cnt_q >= TIME_FIRST) && (byte_cnt_q <= TIME_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_cnt_q <= '0;
            data_q     <= '0;
            data_wr_q  <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            data_q     <= i_data_wr ? iv_data : 8'h00;
            data_wr_q  <= i_data_wr;
        end
    end

    // Frame parser; the byte seen in IDLE is always byte 0 because every path into IDLE
    // is taken on an idle cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q           <= ST_RESYNC;
            pit_sh_q          <= '0;
            time_sh_q         <= '0;
            pit_q             <= '0;
            time_q            <= '0;
            offset_q          <= '0;
            sync_info_valid_q <= 1'b0;
            short_err_q       <= 1'b0;
            pkt_cnt_q         <= '0;
            err_cnt_q         <= '0;
        end else begin
            sync_info_valid_q <= 1'b0;
            short_err_q       <= 1'b0;
            case (state_q)
                ST_RESYNC: begin
                    if (!i_data_wr) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (i_data_wr) begin
                        state_q   <= ST_HEADER;
                        pit_sh_q  <= '0;
                        time_sh_q <= '0;
                    end
                end
                ST_HEADER: begin
                    if (!i_data_wr) begin
                        state_q <= ST_IDLE;
                    end else if (!hdr_byte_ok) begin
                        state_q <= ST_DISCARD;
                    end else if (byte_cnt_q == HDR_LAST) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!i_data_wr) begin
                        short_err_q <= 1'b1;
                        err_cnt_q   <= err_cnt_q + 16'd1;
                        state_q     <= ST_IDLE;
                    end else begin
                        if (in_pit) begin
                            pit_sh_q <= {pit_sh_q[55:0], iv_data};
                        end
                        if (in_time) begin
                            time_sh_q <= {time_sh_q[55:0], iv_data};
                        end
                        if (byte_cnt_q == CAP_LAST) begin
                            state_q <= ST_WAIT_END;
                        end
                    end
                end
                ST_WAIT_END: begin
                    if (!i_data_wr) begin
                        pit_q             <= pit_sh_q;
                        time_q            <= time_sh_q;
                        offset_q          <= pit_sh_q - time_sh_q;
                        sync_info_valid_q <= 1'b1;
                        pkt_cnt_q         <= pkt_cnt_q + 16'd1;
                        state_q           <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (!i_data_wr) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_RESYNC;
            endcase
        end
    end

    assign ov_data           = data_q;
    assign o_data_wr         = data_wr_q;
    assign ov_dispatch_pit   = pit_q;
    assign ov_correct_time   = time_q;
    assign ov_time_offset    = offset_q;
    assign o_sync_info_valid = sync_info_valid_q;
    assign o_sync_short_err  = short_err_q;
    assign ov_sync_pkt_cnt   = pkt_cnt_q;
    assign ov_sync_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_opensync_sync_info_extract.sv
// Directed bench for opensync_sync_info_extract: a table of whole frames with hand-computed
// results, plus sequences for back-to-back frames, very long frames and mid-frame reset.
module tb_opensync_sync_info_extract;

    logic        clk;
    logic        rst_n;
    logic [7:0]  iv_data;
    logic        i_data_wr;
    logic [7:0]  ov_data;
    logic        o_data_wr;
    logic [63:0] ov_dispatch_pit;
    logic [63:0] ov_correct_time;
    logic [63:0] ov_time_offset;
    logic        o_sync_info_valid;
    logic        o_sync_short_err;
    logic [15:0] ov_sync_pkt_cnt;
    logic [15:0] ov_sync_err_cnt;

    opensync_sync_info_extract dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .iv_data           (iv_data),
        .i_data_wr         (i_data_wr),
        .ov_data           (ov_data),
        .o_data_wr         (o_data_wr),
        .ov_dispatch_pit   (ov_dispatch_pit),
        .ov_correct_time   (ov_correct_time),
        .ov_time_offset    (ov_time_offset),
        .o_sync_info_valid (o_sync_info_valid),
        .o_sync_short_err  (o_sync_short_err),
        .ov_sync_pkt_cnt   (ov_sync_pkt_cnt),
        .ov_sync_err_cnt   (ov_sync_err_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        int          len;
        logic [15:0] etype;
        logic [7:0]  mtype;
        logic [7:0]  mstype;
        logic [63:0] pit;
        logic [63:0] tm;
        logic        exp_valid;
        logic        exp_err;
        logic [63:0] exp_pit;
        logic [63:0] exp_time;
        logic [63:0] exp_off;
        logic [15:0] exp_pkt;
        logic [15:0] exp_errc;
    } vec_t;

    localparam int NV = 11;
    vec_t       vecs [NV];
    logic [7:0] fbuf [2200];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [7:0] d, input logic wr);
        iv_data   = d;
        i_data_wr = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic build(input int len, input logic [15:0] et, input logic [7:0] mt,
                         input logic [7:0] st, input logic [63:0] pit, input logic [63:0] tm);
        for (int i = 0; i < len; i++) fbuf[i] = 8'(i * 37 + 5);
        fbuf[12] = et[15:8];
        fbuf[13] = et[7:0];
        fbuf[14] = mt;
        fbuf[15] = st;
        for (int k = 0; k < 8; k++) begin
            fbuf[16 + k] = pit[63 - 8 * k -: 8];
            fbuf[24 + k] = tm[63 - 8 * k -: 8];
        end
    endtask

    // Drives bytes first..last of fbuf and checks each comes out one cycle later.
    task automatic send_range(input int first, input int last, input bit chk);
        for (int i = first; i <= last; i++) begin
            tick(fbuf[i], 1'b1);
            if (chk) check($sformatf("pass_b%0d", i), {55'd0, o_data_wr, ov_data}, {55'd0, 1'b1, fbuf[i]});
        end
    endtask

    task automatic check_event(input string tag, input logic v, input logic e, input logic [63:0] p,
                               input logic [63:0] t, input logic [63:0] o,
                               input logic [15:0] pc, input logic [15:0] ec);
        check({tag, "_valid"}, 64'(o_sync_info_valid), 64'(v));
        check({tag, "_err"},   64'(o_sync_short_err), 64'(e));
        check({tag, "_pit"},   ov_dispatch_pit, p);
        check({tag, "_time"},  ov_correct_time, t);
        check({tag, "_off"},   ov_time_offset, o);
        check({tag, "_pkt"},   64'(ov_sync_pkt_cnt), 64'(pc));
        check({tag, "_errc"},  64'(ov_sync_err_cnt), 64'(ec));
    endtask

    initial begin
        vecs[0]  = '{64, 16'hFF01, 8'h06, 8'h03, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_F000,
                     1'b1, 1'b0, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_1000, 16'd1, 16'd0};
        vecs[1]  = '{32, 16'hFF01, 8'h06, 8'h03, 64'h10, 64'h20,
                     1'b1, 1'b0, 64'h10, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 16'd2, 16'd0};
        vecs[2]  = '{64, 16'h0800, 8'h06, 8'h03, 64'h55, 64'h66,
                     1'b0, 1'b0, 64'h10, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 16'd2, 16'd0};
        vecs[3]  = '{40, 16'hFF01, 8'h06, 8'h03, 64'h0123_4567_89AB_CDEF, 64'h1,
                     1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0123_4567_89AB_CDEE, 16'd3, 16'd0};
        vecs[4]  = '{28, 16'hFF01, 8'h06, 8'h03, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                     1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0123_4567_89AB_CDEE, 16'd3, 16'd1};
        vecs[5]  = '{16, 16'hFF01, 8'h06, 8'h03, 64'h77, 64'h88,
                     1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0123_4567_89AB_CDEE, 16'd3, 16'd2};
        vecs[6]  = '{14, 16'hFF01, 8'h06, 8'h03, 64'h77, 64'h88,
                     1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0123_4567_89AB_CDEE, 16'd3, 16'd2};
        vecs[7]  = '{40, 16'hFF01, 8'h06, 8'h04, 64'h77, 64'h88,
                     1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0123_4567_89AB_CDEE, 16'd3, 16'd2};
        vecs[8]  = '{31, 16'hFF01, 8'h06, 8'h03, 64'h77, 64'h88,
                     1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h0123_4567_89AB_CDEE, 16'd3, 16'd3};
        vecs[9]  = '{33, 16'hFF01, 8'h06, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                     1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd4, 16'd3};
        vecs[10] = '{48, 16'hFF01, 8'h06, 8'h03, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                     1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 16'd5, 16'd3};

        iv_data   = 8'h00;
        i_data_wr = 1'b0;
        rst_n     = 1'b0;
        #20;
        check_event("reset", 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 16'd0, 16'd0);
        check("reset_pass", {55'd0, o_data_wr, ov_data}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);

        for (int v = 0; v < NV; v++) begin
            build(vecs[v].len, vecs[v].etype, vecs[v].mtype, vecs[v].mstype, vecs[v].pit, vecs[v].tm);
            send_range(0, vecs[v].len - 1, 1'b1);
            tick(8'h00, 1'b0);
            check_event($sformatf("v%0d", v), vecs[v].exp_valid, vecs[v].exp_err, vecs[v].exp_pit,
                        vecs[v].exp_time, vecs[v].exp_off, vecs[v].exp_pkt, vecs[v].exp_errc);
            check($sformatf("v%0d_idle_data", v), {55'd0, o_data_wr, ov_data}, 64'h0);
            tick(8'h00, 1'b0);
            check($sformatf("v%0d_valid_drop", v), 64'(o_sync_info_valid), 64'h0);
            check($sformatf("v%0d_err_drop", v), 64'(o_sync_short_err), 64'h0);
        end

        // Non-sync frame followed by a sync frame after a single idle cycle.
        build(64, 16'h0800, 8'h06, 8'h03, 64'h99, 64'h11);
        send_range(0, 63, 1'b1);
        tick(8'h00, 1'b0);
        check("b2b_first_valid", 64'(o_sync_info_valid), 64'h0);
        build(48, 16'hFF01, 8'h06, 8'h03, 64'h1111, 64'h0111);
        send_range(0, 47, 1'b1);
        tick(8'h00, 1'b0);
        check_event("b2b_second", 1'b1, 1'b0, 64'h1111, 64'h0111, 64'h1000, 16'd6, 16'd3);
        tick(8'h00, 1'b0);
        check("b2b_valid_drop", 64'(o_sync_info_valid), 64'h0);

        // Frame well past the byte-counter saturation point.
        build(2100, 16'hFF01, 8'h06, 8'h03, 64'h2222_0000_0000_0000, 64'h1111_0000_0000_0000);
        send_range(0, 2099, 1'b0);
        tick(8'h00, 1'b0);
        check_event("long", 1'b1, 1'b0, 64'h2222_0000_0000_0000, 64'h1111_0000_0000_0000,
                    64'h1111_0000_0000_0000, 16'd7, 16'd3);
        tick(8'h00, 1'b0);

        // Reset asserted at byte 20, released while the frame is still running.
        build(64, 16'hFF01, 8'h06, 8'h03, 64'hDEAD, 64'hBEEF);
        send_range(0, 19, 1'b1);
        iv_data   = fbuf[20];
        i_data_wr = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_event("rst_async", 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 16'd0, 16'd0);
        check("rst_async_pass", {55'd0, o_data_wr, ov_data}, 64'h0);
        @(posedge clk);
        #1;
        send_range(21, 24, 1'b0);
        check("rst_held_pit", ov_dispatch_pit, 64'h0);
        rst_n = 1'b1;
        send_range(25, 63, 1'b1);
        tick(8'h00, 1'b0);
        check_event("rst_tail", 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 16'd0, 16'd0);
        tick(8'h00, 1'b0);
        check("rst_tail_err_late", 64'(o_sync_short_err), 64'h0);
        build(64, 16'hFF01, 8'h06, 8'h03, 64'h3000, 64'h1000);
        send_range(0, 63, 1'b1);
        tick(8'h00, 1'b0);
        check_event("post_rst", 1'b1, 1'b0, 64'h3000, 64'h1000, 64'h2000, 16'd1, 16'd0);
        tick(8'h00, 1'b0);
        check("post_rst_valid_drop", 64'(o_sync_info_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
